// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: funct3 codes, mcause codes,
// FSM state encoding and the funct3 legality rule.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] CAUSE_LOAD_FAULT     = 32'd5;
  localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] CAUSE_STORE_FAULT    = 32'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Stores only have B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3 > F3_W;
    end
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the datapath (master) and the memory responder (slave).
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        except;
  logic [31:0] except_info;
  logic [31:0] except_tval;

  modport master (
    output req_valid, req_we, req_f3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, except, except_info, except_tval
  );

  modport slave (
    input  req_valid, req_we, req_f3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, except, except_info, except_tval
  );

endinterface

// File: rtl/data_mem_responder_ls_lane_align.sv
// Byte-lane steering for a 32-bit load/store port: store lane mask and replicated data,
// extended load result and misalignment flag. Purely combinational.
module ls_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

  // f3[2] selects zero extension, f3[1:0] selects the access size.
  always_comb begin
    o_mask     = 4'b0000;
    o_wword    = i_wdata;
    o_rdata    = i_rword;
    o_misalign = 1'b0;
    case (i_f3[1:0])
      2'b00: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = i_f3[2] ? {24'd0, w_shifted[7:0]}
                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      2'b01: begin
        o_mask     = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wword    = {2{i_wdata[15:0]}};
        o_rdata    = i_f3[2] ? {16'd0, w_shifted[15:0]}
                             : {{16{w_shifted[15]}}, w_shifted[15:0]};
        o_misalign = i_addr_lo[0];
      end
      2'b10: begin
        o_mask     = 4'b1111;
        o_misalign = |i_addr_lo;
      end
      default: begin
        o_mask = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the datapath load/store port: byte-lane RAM with
// configurable wait states and misaligned/access-fault exception reporting.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_responder_if.slave bus
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic        r_resp_valid;
  logic        r_except;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_info;
  logic [31:0] r_tval;

  logic          w_idle;
  logic          w_cur_we;
  logic [2:0]    w_cur_f3;
  logic [31:0]   w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_mask;
  logic [31:0]   w_wword;
  logic [31:0]   w_ram_word;
  logic [31:0]   w_ld_data;
  logic          w_misalign;
  logic          w_fault;
  logic          w_err;
  logic [31:0]   w_cause;
  logic          w_accept;
  logic          w_finish;
  logic          w_commit;

  // While idle the access is evaluated straight off the bus; afterwards from the latch.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_cur_we    = w_idle ? bus.req_we    : r_we;
  assign w_cur_f3    = w_idle ? bus.req_f3    : r_f3;
  assign w_cur_addr  = w_idle ? bus.req_addr  : r_addr;
  assign w_cur_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_idx       = w_cur_addr[AW+1:2];

  ls_lane_align u_align (
    .i_f3       (w_cur_f3),
    .i_addr_lo  (w_cur_addr[1:0]),
    .i_wdata    (w_cur_wdata),
    .i_rword    (w_ram_word),
    .o_mask     (w_mask),
    .o_wword    (w_wword),
    .o_rdata    (w_ld_data),
    .o_misalign (w_misalign)
  );

  assign w_fault  = f3_illegal(w_cur_we, w_cur_f3) || ({1'b0, w_cur_addr} >= BYTE_LIMIT);
  assign w_err    = w_fault || w_misalign;
  assign w_cause  = w_fault ? (w_cur_we ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT)
                            : (w_cur_we ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN);
  assign w_accept = w_idle && bus.req_valid;

  // A legal access completes on the edge that enters RESP; that is the only write edge.
  assign w_finish = rst_n && ((w_accept && !w_err && (WAIT_CYCLES == 0)) ||
                              ((r_state == ST_WAIT) && (r_cnt <= 4'd1)));
  assign w_commit = w_finish && w_cur_we;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [MEM_WORDS];

      always_ff @(posedge clk) begin
        if (w_commit && w_mask[gi]) begin
          r_mem[w_idx] <= w_wword[8*gi +: 8];
        end
      end

      assign w_ram_word[8*gi +: 8] = r_mem[w_idx];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_f3         <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_except     <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_info       <= 32'd0;
      r_tval       <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_except     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_f3    <= bus.req_f3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_ready <= 1'b0;
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_except     <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_info       <= w_cause;
              r_tval       <= bus.req_addr;
            end else if (w_finish) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_cur_we ? 32'd0 : w_ld_data;
              r_info       <= 32'd0;
              r_tval       <= 32'd0;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_finish) begin
            r_state      <= ST_RESP;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_cur_we ? 32'd0 : w_ld_data;
            r_info       <= 32'd0;
            r_tval       <= 32'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.except      = r_except;
  assign bus.except_info = r_info;
  assign bus.except_tval = r_tval;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus random accesses
// against a byte-array reference model.
module tb_data_mem_responder;

  localparam int W_A  = 1;
  localparam int W_B  = 3;
  localparam int MEMW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder_if a_if ();
  data_mem_responder_if b_if ();

  data_mem_responder #(.MEM_WORDS(MEMW), .WAIT_CYCLES(W_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  data_mem_responder #(.MEM_WORDS(MEMW), .WAIT_CYCLES(W_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, size from funct3, little-endian assembly.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err,
                                output logic [31:0] cause, output logic [31:0] rdata);
    int size;
    logic illegal, oob, mis;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (we) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    oob   = (addr >= 32'(4 * MEMW));
    mis   = ((addr % 32'(size)) != 32'd0);
    err   = illegal || oob || mis;
    cause = 32'd0;
    rdata = 32'd0;
    if (illegal || oob) begin
      cause = we ? 32'd7 : 32'd5;
    end else if (mis) begin
      cause = we ? 32'd6 : 32'd4;
    end else if (we) begin
      for (int k = 0; k < size; k++) mdl[8'(addr + 32'(k))] = wdata[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v = v | (32'(mdl[8'(addr + 32'(k))]) << (8 * k));
      if (!f3[2] && (size < 4) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rdata = v;
    end
  endfunction

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] got);
    logic exp_err;
    logic [31:0] exp_cause, exp_rdata;
    int lat;
    model(we, f3, addr, wdata, exp_err, exp_cause, exp_rdata);
    @(negedge clk);
    check("ready_before", 32'(a_if.req_ready), 32'd1);
    a_if.req_we    = we;
    a_if.req_f3    = f3;
    a_if.req_addr  = addr;
    a_if.req_wdata = wdata;
    a_if.req_valid = 1'b1;
    @(posedge clk);
    #1 a_if.req_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (a_if.resp_valid === 1'b1 || lat >= 30) break;
    end
    got = a_if.resp_rdata;
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> lat=%0d rdata=%h exc=%0d info=%0d tval=%h",
             we, f3, addr, wdata, lat, a_if.resp_rdata, a_if.except, a_if.except_info,
             a_if.except_tval);
    check("latency", 32'(lat), exp_err ? 32'd1 : 32'(1 + W_A));
    check("resp_valid", 32'(a_if.resp_valid), 32'd1);
    check("rdata", a_if.resp_rdata, exp_rdata);
    check("except", 32'(a_if.except), 32'(exp_err));
    if (exp_err) begin
      check("except_info", a_if.except_info, exp_cause);
      check("except_tval", a_if.except_tval, addr);
    end
    @(negedge clk);
    check("resp_pulse_end", 32'(a_if.resp_valid), 32'd0);
    check("except_pulse_end", 32'(a_if.except), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int lat, nresp, nlow;

    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_f3 = 3'd0;
    a_if.req_addr = 32'd0; a_if.req_wdata = 32'd0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_f3 = 3'd0;
    b_if.req_addr = 32'd0; b_if.req_wdata = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(a_if.req_ready), 32'd1);
    check("rst_resp_valid", 32'(a_if.resp_valid), 32'd0);
    check("rst_except", 32'(a_if.except), 32'd0);
    check("rst_rdata", a_if.resp_rdata, 32'd0);
    check("rst_info", a_if.except_info, 32'd0);
    check("rst_tval", a_if.except_tval, 32'd0);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a += 4) txn(1'b1, 3'b010, 32'(a), $urandom, got);

    txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, got);
    txn(1'b0, 3'b010, 32'h10, 32'd0, got);
    check("lw_deadbeef", got, 32'hDEAD_BEEF);
    txn(1'b1, 3'b010, 32'h10, 32'h0, got);
    txn(1'b1, 3'b000, 32'h11, 32'h80, got);
    txn(1'b0, 3'b000, 32'h11, 32'd0, got);
    check("lb_sext", got, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h11, 32'd0, got);
    check("lbu_zext", got, 32'h0000_0080);
    txn(1'b0, 3'b010, 32'h10, 32'd0, got);
    check("lw_after_sb", got, 32'h0000_8000);
    txn(1'b0, 3'b001, 32'h13, 32'd0, got);
    txn(1'b1, 3'b010, 32'h22, 32'h5555_AAAA, got);
    txn(1'b0, 3'b010, 32'h20, 32'd0, got);
    txn(1'b0, 3'b010, 32'h1000, 32'd0, got);
    txn(1'b1, 3'b011, 32'h40, 32'h1234_5678, got);

    for (int i = 0; i < 40; i++) begin
      logic rwe;
      logic [2:0] rf3;
      logic [31:0] raddr;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) raddr = 32'h1000 + 32'($urandom_range(0, 4095));
      else                           raddr = 32'($urandom_range(0, 255));
      txn(rwe, rf3, raddr, $urandom, got);
    end

    // Request held valid for the whole access on the 3-wait instance.
    @(negedge clk);
    b_if.req_we = 1'b1; b_if.req_f3 = 3'b010; b_if.req_addr = 32'h40;
    b_if.req_wdata = 32'hA5A5_5A5A; b_if.req_valid = 1'b1;
    nresp = 0;
    nlow = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_if.req_ready === 1'b0) nlow++;
      if (b_if.resp_valid === 1'b1) begin
        nresp++;
        b_if.req_valid = 1'b0;
      end
    end
    $display("txn hold SW on W=3: resp_count=%0d ready_low=%0d", nresp, nlow);
    check("hold_resp_count", 32'(nresp), 32'd1);
    check("hold_ready_low", 32'(nlow), 32'(W_B + 1));

    @(negedge clk);
    b_if.req_we = 1'b0; b_if.req_f3 = 3'b010; b_if.req_addr = 32'h40; b_if.req_valid = 1'b1;
    @(posedge clk);
    #1 b_if.req_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (b_if.resp_valid === 1'b1 || lat >= 30) break;
    end
    $display("txn LW on W=3 addr=00000040 -> lat=%0d rdata=%h", lat, b_if.resp_rdata);
    check("b_latency", 32'(lat), 32'(1 + W_B));
    check("b_rdata", b_if.resp_rdata, 32'hA5A5_5A5A);

    // Reset while a store sits in WAIT: no response, RAM untouched.
    @(negedge clk);
    @(negedge clk);
    a_if.req_we = 1'b1; a_if.req_f3 = 3'b010; a_if.req_addr = 32'h30;
    a_if.req_wdata = 32'h1234_5678; a_if.req_valid = 1'b1;
    @(posedge clk);
    #1 a_if.req_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(a_if.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(a_if.req_ready), 32'd1);
    nresp = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_if.resp_valid !== 1'b0 || a_if.except !== 1'b0) nresp++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (a_if.resp_valid !== 1'b0 || a_if.except !== 1'b0) nresp++;
    end
    $display("txn SW aborted by reset addr=00000030 -> stray_responses=%0d", nresp);
    check("mid_no_resp", 32'(nresp), 32'd0);
    txn(1'b0, 3'b010, 32'h30, 32'd0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
